// File: rtl/regfile_write_arbiter.sv
//==============================================================================
// Module  : regfile_write_arbiter
// Brief   : Two-requester register-file write arbiter with post-reset clear
//           sequence, round-robin conflict resolution and conflict counter.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module regfile_write_arbiter #(
    parameter int CLEAR_EN = 1,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             A_valid,
    input  logic [4:0]       A_rw,
    input  logic [63:0]      A_data,
    output logic             A_ready,
    input  logic             B_valid,
    input  logic [4:0]       B_rw,
    input  logic [63:0]      B_data,
    output logic             B_ready,
    output logic             RegWr,
    output logic [4:0]       RW,
    output logic [63:0]      BusW,
    output logic             Busy,
    output logic [CNT_W-1:0] Conflict_cnt
);

    localparam logic [0:0]       c_ST_CLEAR  = 1'b0;
    localparam logic [0:0]       c_ST_RUN    = 1'b1;
    localparam logic [0:0]       c_ST_RESET  = (CLEAR_EN != 0) ? c_ST_CLEAR : c_ST_RUN;
    localparam logic [4:0]       c_LAST_IDX  = 5'd30;
    localparam logic [4:0]       c_ZERO_REG  = 5'd31;
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [4:0]       r_idx;
    logic             r_last_b;
    logic             r_regwr;
    logic [4:0]       r_rw;
    logic [63:0]      r_busw;
    logic [CNT_W-1:0] r_cnt;

    logic             w_run;
    logic             w_busy;
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_xfer_a;
    logic             w_xfer_b;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_CLEAR: if (r_idx == c_LAST_IDX) w_state_nxt = c_ST_RUN;
            default:    w_state_nxt = c_ST_RUN;
        endcase
    end

    // Output logic; ready is gated by Reset_n so it falls as soon as reset asserts
    always_comb begin
        w_busy    = (r_state == c_ST_CLEAR);
        w_run     = (r_state == c_ST_RUN) && Reset_n;
        w_grant_a = A_valid && (!B_valid || r_last_b);
        w_grant_b = B_valid && (!A_valid || !r_last_b);
        w_xfer_a  = w_run && w_grant_a;
        w_xfer_b  = w_run && w_grant_b;
    end

    // r_last_b records the most recent winner; reset value 1 lets A win first
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_idx    <= 5'd0;
            r_last_b <= 1'b1;
            r_regwr  <= 1'b0;
            r_rw     <= 5'd0;
            r_busw   <= 64'd0;
        end else if (r_state == c_ST_CLEAR) begin
            r_idx    <= r_idx + 5'd1;
            r_regwr  <= 1'b1;
            r_rw     <= r_idx;
            r_busw   <= 64'd0;
        end else if (w_xfer_a) begin
            r_last_b <= 1'b0;
            r_regwr  <= (A_rw != c_ZERO_REG);
            r_rw     <= A_rw;
            r_busw   <= A_data;
        end else if (w_xfer_b) begin
            r_last_b <= 1'b1;
            r_regwr  <= (B_rw != c_ZERO_REG);
            r_rw     <= B_rw;
            r_busw   <= B_data;
        end else begin
            r_regwr  <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if ((r_state == c_ST_RUN) && A_valid && B_valid && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign A_ready      = w_xfer_a;
    assign B_ready      = w_xfer_b;
    assign Busy         = w_busy;
    assign RegWr        = r_regwr;
    assign RW           = r_rw;
    assign BusW         = r_busw;
    assign Conflict_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
//==============================================================================
// Module  : tb_regfile_write_arbiter
// Brief   : Directed self-checking bench for regfile_write_arbiter.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

    localparam int CNT_W = 4;

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic             A_valid;
    logic [4:0]       A_rw;
    logic [63:0]      A_data;
    logic             A_ready;
    logic             B_valid;
    logic [4:0]       B_rw;
    logic [63:0]      B_data;
    logic             B_ready;
    logic             RegWr;
    logic [4:0]       RW;
    logic [63:0]      BusW;
    logic             Busy;
    logic [CNT_W-1:0] Conflict_cnt;

    int n_cmp = 0;
    int n_err = 0;

    regfile_write_arbiter #(
        .CLEAR_EN (1),
        .CNT_W    (CNT_W)
    ) u_dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .A_valid      (A_valid),
        .A_rw         (A_rw),
        .A_data       (A_data),
        .A_ready      (A_ready),
        .B_valid      (B_valid),
        .B_rw         (B_rw),
        .B_data       (B_data),
        .B_ready      (B_ready),
        .RegWr        (RegWr),
        .RW           (RW),
        .BusW         (BusW),
        .Busy         (Busy),
        .Conflict_cnt (Conflict_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n = 1'b0;
        A_valid = 1'b1; A_rw = 5'd5; A_data = 64'h1234;
        B_valid = 1'b0; B_rw = 5'd0; B_data = 64'h0;

        // Reset values
        #23;
        chk("rst_regwr", RegWr, 0);
        chk("rst_rw", RW, 0);
        chk("rst_busw", BusW, 0);
        chk("rst_busy", Busy, 1);
        chk("rst_aready", A_ready, 0);
        chk("rst_bready", B_ready, 0);
        chk("rst_cnt", Conflict_cnt, 0);

        // Clear sequence: 31 writes of zero to X0..X30, A held pending throughout
        Reset_n = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            chk("clr_busy", Busy, 1);
            chk("clr_aready", A_ready, 0);
            tick();
            chk("clr_regwr", RegWr, 1);
            chk("clr_rw", RW, 64'(i));
            chk("clr_busw", BusW, 0);
        end

        // First RUN cycle: A accepted
        chk("run_busy", Busy, 0);
        chk("a_only_ready", A_ready, 1);
        chk("a_only_bready", B_ready, 0);
        tick();
        A_valid = 1'b0;
        chk("a_only_regwr", RegWr, 1);
        chk("a_only_rw", RW, 5);
        chk("a_only_busw", BusW, 64'h1234);
        tick();
        chk("idle_regwr", RegWr, 0);

        // B-only write so the pointer favours A for the next conflict
        B_valid = 1'b1; B_rw = 5'd7; B_data = 64'hBEEF;
        #1;
        chk("b_only_ready", B_ready, 1);
        tick();
        B_valid = 1'b0;
        chk("b_only_rw", RW, 7);
        chk("b_only_busw", BusW, 64'hBEEF);

        // Four-cycle conflict: A,B,A,B
        A_valid = 1'b1; A_rw = 5'd1; A_data = 64'hA1;
        B_valid = 1'b1; B_rw = 5'd2; B_data = 64'hB2;
        #1;
        chk("cf1_aready", A_ready, 1);
        chk("cf1_bready", B_ready, 0);
        tick();
        chk("cf1_regwr", RegWr, 1);
        chk("cf1_rw", RW, 1);
        chk("cf1_busw", BusW, 64'hA1);
        chk("cf1_cnt", Conflict_cnt, 1);
        A_rw = 5'd3; A_data = 64'hA3;
        #1;
        chk("cf2_bready", B_ready, 1);
        chk("cf2_aready", A_ready, 0);
        tick();
        chk("cf2_regwr", RegWr, 1);
        chk("cf2_rw", RW, 2);
        chk("cf2_busw", BusW, 64'hB2);
        chk("cf2_cnt", Conflict_cnt, 2);
        B_rw = 5'd4; B_data = 64'hB4;
        #1;
        chk("cf3_aready", A_ready, 1);
        tick();
        chk("cf3_regwr", RegWr, 1);
        chk("cf3_rw", RW, 3);
        chk("cf3_busw", BusW, 64'hA3);
        chk("cf3_cnt", Conflict_cnt, 3);
        A_valid = 1'b0;
        #1;
        chk("cf4_bready", B_ready, 1);
        tick();
        B_valid = 1'b0;
        chk("cf4_regwr", RegWr, 1);
        chk("cf4_rw", RW, 4);
        chk("cf4_busw", BusW, 64'hB4);
        chk("cf4_cnt", Conflict_cnt, 3);

        // Write to X31 accepted but suppressed; pointer still moves to A
        A_valid = 1'b1; A_rw = 5'd31; A_data = 64'hDEAD;
        #1;
        chk("x31_aready", A_ready, 1);
        tick();
        chk("x31_regwr", RegWr, 0);
        A_rw = 5'd8; A_data = 64'h88;
        B_valid = 1'b1; B_rw = 5'd9; B_data = 64'h99;
        #1;
        chk("x31_next_bready", B_ready, 1);
        chk("x31_next_aready", A_ready, 0);
        tick();
        B_valid = 1'b0;
        chk("x31_next_rw", RW, 9);
        chk("x31_next_busw", BusW, 64'h99);
        chk("x31_next_cnt", Conflict_cnt, 4);
        #1;
        chk("a_held_ready", A_ready, 1);
        tick();
        chk("a_held_rw", RW, 8);
        chk("a_held_busw", BusW, 64'h88);

        // Same rw conflict, then saturate the counter (2^CNT_W + 3 cycles)
        A_rw = 5'd10; A_data = 64'hAA;
        B_valid = 1'b1; B_rw = 5'd10; B_data = 64'hBB;
        tick();
        chk("same_rw_first", BusW, 64'hBB);
        tick();
        chk("same_rw_second", BusW, 64'hAA);
        chk("same_rw_regwr", RegWr, 1);
        for (int i = 2; i < (1 << CNT_W) + 3; i++) tick();
        chk("cnt_sat", Conflict_cnt, (1 << CNT_W) - 1);
        A_valid = 1'b0; B_valid = 1'b0;
        tick();
        chk("cnt_hold", Conflict_cnt, (1 << CNT_W) - 1);

        // Reset mid-RUN with a pending request, then abort CLEAR at index 12
        A_valid = 1'b1; A_rw = 5'd6; A_data = 64'h66;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("mrun_rst_aready", A_ready, 0);
        chk("mrun_rst_busy", Busy, 1);
        chk("mrun_rst_cnt", Conflict_cnt, 0);
        A_valid = 1'b0;
        Reset_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("pre_abort_rw", RW, 11);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("abort_regwr", RegWr, 0);
        chk("abort_rw", RW, 0);
        chk("abort_busw", BusW, 0);
        chk("abort_busy", Busy, 1);
        Reset_n = 1'b1;
        tick();
        chk("restart_regwr", RegWr, 1);
        chk("restart_rw", RW, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish, expected finish before 20000");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have a parameter CLEAR_EN, default 1, meaning 1 = zero X0..X30 after reset and 0 = skip clearing.
REQ-002 The block SHALL have a parameter CNT_W, default 16, meaning the width of the conflict counter.
REQ-003 Port Clk  input  1  single clock; all state changes on posedge.
REQ-004 Port Reset_n  input  1  reset; asynchronous, active-low.
REQ-005 Port A_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-006 Port A_rw  input  5  requester A destination register.
REQ-007 Port A_data  input  64  requester A write data.
REQ-008 Port A_ready  output  1  requester A write accepted this cycle.
REQ-009 Port B_valid, B_rw, B_data, B_ready SHALL mirror the A ports (load writeback), with identical widths and directions.
REQ-010 Port RegWr  output  1  register-file write enable (registered).
REQ-011 Port RW  output  5  register-file write address (registered).
REQ-012 Port BusW  output  64  register-file write data (registered).
REQ-013 Port Busy  output  1  high while the clear sequence runs.
REQ-014 Port Conflict_cnt  output  CNT_W  count of cycles with both requesters valid in RUN.

Function
REQ-015 The FSM SHALL have two states: CLEAR and RUN.
REQ-016 CLEAR SHALL be entered on reset release when CLEAR_EN=1; RUN SHALL be entered directly when CLEAR_EN=0.
REQ-017 In CLEAR, a 5-bit index SHALL step 0..30, one per cycle, and each cycle SHALL register RegWr=1, RW=index, BusW=0.
REQ-018 After index 30 is issued, the FSM SHALL go to RUN; CLEAR SHALL last exactly 31 cycles; X31 SHALL never be written.
REQ-019 In CLEAR: Busy=1 and A_ready=B_ready=0; Busy SHALL drop in the first RUN cycle.
REQ-020 In RUN, grant SHALL be combinational: only A valid -> A; only B valid -> B; both valid -> the requester not granted most recently (round-robin pointer).
REQ-021 The round-robin pointer SHALL reset to favour A, and SHALL update only on an accepted transfer.
REQ-022 X_ready SHALL equal (state==RUN && grant==X); a transfer occurs when X_valid && X_ready.
REQ-023 A requester SHALL hold valid, rw and data stable until accepted; a non-granted requester SHALL remain not-ready that cycle with no data loss.
REQ-024 An accepted write SHALL appear on RegWr/RW/BusW on the next posedge (latency 1).
REQ-025 RegWr SHALL be 0 in any RUN cycle following a cycle with no transfer.
REQ-026 A write to rw=31 SHALL be accepted (ready asserted, pointer updated) but SHALL register RegWr=0, with RW/BusW don't-care.
REQ-027 One write per cycle maximum; sustained throughput SHALL be 1 write/cycle with either or both requesters active.
REQ-028 Both valid with the same rw SHALL be treated as an ordinary conflict: the winner writes first and the loser writes the following cycle, so the loser's data is final.
REQ-029 Conflict_cnt SHALL increment in each RUN cycle with A_valid && B_valid and SHALL saturate at all-ones.

Reset
REQ-030 Reset_n low SHALL asynchronously force RegWr=0, RW=0, BusW=0, index=0, pointer=A, Conflict_cnt=0, and A_ready=B_ready=0.
REQ-031 During reset, Busy SHALL equal CLEAR_EN and the state SHALL be CLEAR when CLEAR_EN=1, RUN otherwise.
REQ-032 Reset asserted mid-CLEAR or mid-RUN SHALL abort all activity, drop any pending ungranted request, and restart per REQ-016 on release.

Verification
REQ-033 Release reset with CLEAR_EN=1 -> 31 consecutive cycles RegWr=1, RW=0..30, BusW=0, Busy=1, and ready low; then Busy=0.
REQ-034 In RUN, drive A only (rw=5, data=0x1234) for one cycle -> A_ready=1, and the next cycle RegWr=1, RW=5, BusW=0x1234.
REQ-035 Hold A and B valid for 4 cycles with distinct rw -> grants A,B,A,B, RegWr high 4 consecutive cycles, and Conflict_cnt increments per cycle valid overlap.
REQ-036 A valid with rw=31 -> A_ready=1, the next cycle RegWr=0, and the pointer flips so a following A/B conflict grants B.
REQ-037 Assert Reset_n low at CLEAR index 12 -> outputs clear immediately; on release CLEAR restarts at RW=0.
REQ-038 Force 2^CNT_W+3 conflict cycles -> Conflict_cnt holds all-ones.
